// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU memory port arbiter.
// The MEM_ARB_PERF_EN macro enables the optional performance counters.
package mem_port_arbiter_pkg;

  localparam int MEM_ARB_AW     = 32;
  localparam int MEM_ARB_DW     = 64;
  localparam int MEM_ARB_PERF_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_LSU = 2'd1,
    ST_WAIT_IFU = 2'd2,
    ST_DROP     = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_arb_perf_cnt.sv
// Free-running grant/stall event counters for the memory port arbiter.
// Only instantiated when MEM_ARB_PERF_EN is defined; counters wrap naturally.
module mem_arb_perf_cnt
  import mem_port_arbiter_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ifu_grant,
  input  logic                      lsu_grant,
  input  logic                      ifu_stall,
  output logic [MEM_ARB_PERF_W-1:0] perf_ifu_grants,
  output logic [MEM_ARB_PERF_W-1:0] perf_lsu_grants,
  output logic [MEM_ARB_PERF_W-1:0] perf_ifu_stall
);

  logic [2:0]                events;
  logic [MEM_ARB_PERF_W-1:0] count_reg [3];

  assign events = {ifu_stall, lsu_grant, ifu_grant};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (rst) begin
          count_reg[gi] <= '0;
        end else if (events[gi]) begin
          count_reg[gi] <= count_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign perf_ifu_grants = count_reg[0];
  assign perf_lsu_grants = count_reg[1];
  assign perf_ifu_stall  = count_reg[2];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IFU and LSU: one outstanding transaction, LSU priority,
// flushed fetches dropped. Define MEM_ARB_PERF_EN to add the perf counter ports.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW = MEM_ARB_AW,
  parameter int DW = MEM_ARB_DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pipeline_flush,
  input  logic            ifu_req_valid,
  input  logic [AW-1:0]   ifu_req_addr,
  output logic            ifu_req_ready,
  output logic            ifu_resp_valid,
  output logic [DW-1:0]   ifu_resp_data,
  input  logic            lsu_req_valid,
  input  logic            lsu_req_wen,
  input  logic [AW-1:0]   lsu_req_addr,
  input  logic [DW-1:0]   lsu_req_wdata,
  input  logic [DW/8-1:0] lsu_req_wmask,
  output logic            lsu_req_ready,
  output logic            lsu_resp_valid,
  output logic [DW-1:0]   lsu_resp_rdata,
  output logic            mem_req_valid,
  output logic            mem_req_wen,
  output logic [AW-1:0]   mem_req_addr,
  output logic [DW-1:0]   mem_req_wdata,
  output logic [DW/8-1:0] mem_req_wmask,
  input  logic            mem_req_ready,
  input  logic            mem_resp_valid,
  input  logic [DW-1:0]   mem_resp_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [63:0]     perf_ifu_grants,
  output logic [63:0]     perf_lsu_grants,
  output logic [63:0]     perf_ifu_stall
`endif
);

  arb_state_e state_reg;
  logic       lsu_wen_reg;
  logic       idle;
  logic       ifu_eff;
  logic       req_fire;

  // Outputs are held at zero while reset is asserted, whatever the state register holds.
  assign idle     = (state_reg == ST_IDLE) && !rst;
  assign ifu_eff  = ifu_req_valid && !pipeline_flush;
  assign req_fire = mem_req_valid && mem_req_ready;

  always_comb begin
    mem_req_valid  = 1'b0;
    mem_req_wen    = 1'b0;
    mem_req_addr   = '0;
    mem_req_wdata  = '0;
    mem_req_wmask  = '0;
    lsu_req_ready  = 1'b0;
    ifu_req_ready  = 1'b0;
    lsu_resp_valid = 1'b0;
    lsu_resp_rdata = '0;
    ifu_resp_valid = 1'b0;
    ifu_resp_data  = '0;

    if (idle) begin
      mem_req_valid = lsu_req_valid || ifu_eff;
      if (lsu_req_valid) begin
        mem_req_wen   = lsu_req_wen;
        mem_req_addr  = lsu_req_addr;
        mem_req_wdata = lsu_req_wdata;
        mem_req_wmask = lsu_req_wmask;
      end else if (ifu_eff) begin
        mem_req_addr  = ifu_req_addr;
      end
      lsu_req_ready = mem_req_ready && lsu_req_valid;
      ifu_req_ready = mem_req_ready && ifu_eff && !lsu_req_valid;
    end

    if (!rst && state_reg == ST_WAIT_LSU && mem_resp_valid) begin
      lsu_resp_valid = 1'b1;
      lsu_resp_rdata = lsu_wen_reg ? '0 : mem_resp_rdata;
    end

    // A flush coinciding with the fetch response discards it.
    if (!rst && state_reg == ST_WAIT_IFU && mem_resp_valid && !pipeline_flush) begin
      ifu_resp_valid = 1'b1;
      ifu_resp_data  = mem_resp_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      lsu_wen_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_fire) begin
            state_reg   <= lsu_req_valid ? ST_WAIT_LSU : ST_WAIT_IFU;
            lsu_wen_reg <= lsu_req_wen;
          end
        end
        ST_WAIT_LSU: begin
          if (mem_resp_valid) state_reg <= ST_IDLE;
        end
        ST_WAIT_IFU: begin
          if (mem_resp_valid)      state_reg <= ST_IDLE;
          else if (pipeline_flush) state_reg <= ST_DROP;
        end
        ST_DROP: begin
          if (mem_resp_valid) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  mem_arb_perf_cnt u_perf (
    .clk             (clk),
    .rst             (rst),
    .ifu_grant       (ifu_req_valid && ifu_req_ready),
    .lsu_grant       (lsu_req_valid && lsu_req_ready),
    .ifu_stall       (ifu_req_valid && !ifu_req_ready),
    .perf_ifu_grants (perf_ifu_grants),
    .perf_lsu_grants (perf_lsu_grants),
    .perf_ifu_stall  (perf_ifu_stall)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter; transactions are queued at acceptance
// and checked when the memory responds. Perf counters are checked when MEM_ARB_PERF_EN is set.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam int NCYC = 1500;

  logic            clk = 1'b0;
  logic            rst;
  logic            pipeline_flush;
  logic            ifu_req_valid;
  logic [AW-1:0]   ifu_req_addr;
  logic            ifu_req_ready;
  logic            ifu_resp_valid;
  logic [DW-1:0]   ifu_resp_data;
  logic            lsu_req_valid;
  logic            lsu_req_wen;
  logic [AW-1:0]   lsu_req_addr;
  logic [DW-1:0]   lsu_req_wdata;
  logic [DW/8-1:0] lsu_req_wmask;
  logic            lsu_req_ready;
  logic            lsu_resp_valid;
  logic [DW-1:0]   lsu_resp_rdata;
  logic            mem_req_valid;
  logic            mem_req_wen;
  logic [AW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_req_wdata;
  logic [DW/8-1:0] mem_req_wmask;
  logic            mem_req_ready;
  logic            mem_resp_valid;
  logic [DW-1:0]   mem_resp_rdata;
`ifdef MEM_ARB_PERF_EN
  logic [63:0]     perf_ifu_grants;
  logic [63:0]     perf_lsu_grants;
  logic [63:0]     perf_ifu_stall;
`endif

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .pipeline_flush (pipeline_flush),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_addr   (ifu_req_addr),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_resp_data  (ifu_resp_data),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_wen    (lsu_req_wen),
    .lsu_req_addr   (lsu_req_addr),
    .lsu_req_wdata  (lsu_req_wdata),
    .lsu_req_wmask  (lsu_req_wmask),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_resp_rdata (lsu_resp_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_wen    (mem_req_wen),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wmask  (mem_req_wmask),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_ifu_grants(perf_ifu_grants),
    .perf_lsu_grants(perf_lsu_grants),
    .perf_ifu_stall (perf_ifu_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_lsu;
    bit          wen;
    logic [31:0] addr;
    logic [63:0] data;
    bit          cancel;
  } txn_t;

  txn_t q[$];
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   n_txn  = 0;
  bit   done   = 1'b0;

  // The bench memory returns a fixed function of the address.
  function automatic logic [63:0] mem_fn(input logic [31:0] a);
    return {a ^ 32'h5A5A_5A5A, ~a + 32'h0000_1234};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver: requesters, flush, reset and a variable-latency memory.
  initial begin
    bit          s_ifu_hs, s_lsu_hs, s_mem_hs;
    logic [31:0] s_addr, paddr;
    bit          mem_pend, pend_ifu, rst_done;
    int          cnt, stall_left, rst_left;
    mem_pend = 0; pend_ifu = 0; rst_done = 0; cnt = 0; stall_left = 0; rst_left = 0;
    paddr = '0;
    rst = 1'b1; pipeline_flush = 1'b0;
    ifu_req_valid = 1'b0; ifu_req_addr = '0;
    lsu_req_valid = 1'b0; lsu_req_wen = 1'b0; lsu_req_addr = '0;
    lsu_req_wdata = '0; lsu_req_wmask = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      s_ifu_hs = ifu_req_valid && ifu_req_ready;
      s_lsu_hs = lsu_req_valid && lsu_req_ready;
      s_mem_hs = mem_req_valid && mem_req_ready;
      s_addr   = mem_req_addr;
      @(posedge clk);
      #1;
      mem_resp_valid = 1'b0;
      mem_resp_rdata = {$urandom, $urandom};
      if (rst_left > 0) begin
        rst_left--;
        rst = (rst_left != 0);
      end else if (!rst_done && cyc >= 400 && mem_pend && pend_ifu) begin
        rst = 1'b1; rst_left = 2; rst_done = 1; mem_pend = 0;
      end
      if (!rst) begin
        if (s_mem_hs) begin
          mem_pend = 1; cnt = $urandom_range(1, 3); paddr = s_addr; pend_ifu = !s_lsu_hs;
        end
        if (mem_pend) begin
          cnt--;
          if (cnt == 0) begin
            mem_resp_valid = 1'b1; mem_resp_rdata = mem_fn(paddr); mem_pend = 0;
          end
        end
      end
      if (stall_left > 0) begin
        stall_left--; mem_req_ready = 1'b0;
      end else if ($urandom % 16 == 0) begin
        stall_left = 4; mem_req_ready = 1'b0;
      end else begin
        mem_req_ready = ($urandom % 4 != 0);
      end
      if (s_lsu_hs) lsu_req_valid = 1'b0;
      if (!lsu_req_valid && ($urandom % 3 == 0)) begin
        lsu_req_valid = 1'b1;
        lsu_req_wen   = $urandom % 2;
        lsu_req_addr  = $urandom & 32'hFFFF_FFF8;
        lsu_req_wdata = {$urandom, $urandom};
        lsu_req_wmask = 8'($urandom);
      end
      if (s_ifu_hs) ifu_req_valid = 1'b0;
      if (!ifu_req_valid && ($urandom % 2 == 0)) begin
        ifu_req_valid = 1'b1;
        ifu_req_addr  = $urandom & 32'hFFFF_FFFC;
      end
      pipeline_flush = ($urandom % 8 == 0);
    end
    done = 1'b1;
    repeat (2) @(negedge clk);
    check("activity", 128'(n_txn > 50), 128'(1));
    check("reset_seen", 128'(rst_done), 128'(1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Monitor and reference model.
  initial begin
    bit          busy, idle_m, ifu_eff, prev_rst;
    bit          e_mv, e_wen, e_lr, e_ir, e_iv, e_lv;
    logic [31:0] e_addr;
    logic [63:0] e_wdata, e_id, e_ld;
    logic [7:0]  e_wmask;
    logic [63:0] m_ifu_g, m_lsu_g, m_stall;
    txn_t        t;
    busy = 0; prev_rst = 0; m_ifu_g = 0; m_lsu_g = 0; m_stall = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      if (rst) begin
        check("rst_ctl", 128'({ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid,
                               mem_req_valid, mem_req_wen}), 128'(0));
        check("rst_resp_data", {ifu_resp_data, lsu_resp_rdata}, 128'(0));
        check("rst_req_data", 128'({mem_req_addr, mem_req_wdata, mem_req_wmask}), 128'(0));
`ifdef MEM_ARB_PERF_EN
        if (prev_rst)
          check("rst_perf", 128'({perf_ifu_grants | perf_lsu_grants | perf_ifu_stall}), 128'(0));
`endif
        q.delete(); busy = 0; m_ifu_g = 0; m_lsu_g = 0; m_stall = 0;
        prev_rst = 1;
        continue;
      end
      prev_rst = 0;
      idle_m  = !busy;
      ifu_eff = ifu_req_valid && !pipeline_flush;
      e_mv = idle_m && (lsu_req_valid || ifu_eff);
      e_wen = 0; e_addr = '0; e_wdata = '0; e_wmask = '0;
      if (idle_m && lsu_req_valid) begin
        e_wen = lsu_req_wen; e_addr = lsu_req_addr; e_wdata = lsu_req_wdata; e_wmask = lsu_req_wmask;
      end else if (idle_m && ifu_eff) begin
        e_addr = ifu_req_addr;
      end
      e_lr = idle_m && mem_req_ready && lsu_req_valid;
      e_ir = idle_m && mem_req_ready && ifu_eff && !lsu_req_valid;
      check("mem_req", 128'({mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wmask}),
            128'({e_mv, e_wen, e_addr, e_wmask}));
      check("mem_wdata", 128'(mem_req_wdata), 128'(e_wdata));
      check("req_ready", 128'({lsu_req_ready, ifu_req_ready}), 128'({e_lr, e_ir}));

      e_iv = 0; e_id = '0; e_lv = 0; e_ld = '0;
      if (busy && (mem_resp_valid || ifu_resp_valid || lsu_resp_valid) && mem_resp_valid) begin
        t = q.pop_front();
        busy = 0;
        n_txn++;
        if (t.is_lsu) begin
          e_lv = 1; e_ld = t.wen ? 64'h0 : t.data;
          $display("txn lsu %s addr=%h rdata=%h", t.wen ? "store" : "load ", t.addr, e_ld);
        end else if (t.cancel || pipeline_flush) begin
          $display("txn ifu fetch addr=%h dropped by flush", t.addr);
        end else begin
          e_iv = 1; e_id = t.data;
          $display("txn ifu fetch addr=%h data=%h", t.addr, e_id);
        end
      end
      check("ifu_resp", {63'(0), e_iv, e_id}, {63'(0), ifu_resp_valid, ifu_resp_data});
      check("lsu_resp", {63'(0), e_lv, e_ld}, {63'(0), lsu_resp_valid, lsu_resp_rdata});

`ifdef MEM_ARB_PERF_EN
      check("perf_ifu_grants", 128'(perf_ifu_grants), 128'(m_ifu_g));
      check("perf_lsu_grants", 128'(perf_lsu_grants), 128'(m_lsu_g));
      check("perf_ifu_stall",  128'(perf_ifu_stall),  128'(m_stall));
`endif
      m_ifu_g += 64'(e_ir);
      m_lsu_g += 64'(e_lr);
      m_stall += 64'(ifu_req_valid && !e_ir);

      if (busy && pipeline_flush && !q[0].is_lsu) q[0].cancel = 1;
      if (idle_m && e_mv && mem_req_ready) begin
        t.is_lsu = lsu_req_valid;
        t.wen    = lsu_req_valid && lsu_req_wen;
        t.addr   = e_addr;
        t.data   = mem_fn(e_addr);
        t.cancel = 0;
        q.push_back(t);
        busy = 1;
      end
    end
  end

endmodule
